// File: rtl/fma_pkg.sv
// Shared FP32 constants and the controller state encoding for the
// sequential fused multiply-add dot-product initiator.
package fma_pkg;

    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;
    localparam int unsigned FP_W  = 32;

    localparam logic [FP_W-1:0] FP_POS_ZERO = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/fma_dot_seq_if.sv
// Operand stream, FMA-core bus and result stream of fma_dot_seq.
// The slave modport is the controller's view; master is the environment.
interface fma_dot_seq_if #(
    parameter int unsigned CNT_W = 16
);
    import fma_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [FP_W-1:0]  in_a;
    logic [FP_W-1:0]  in_b;
    logic             in_last;
    logic [FP_W-1:0]  fma_a;
    logic [FP_W-1:0]  fma_b;
    logic [FP_W-1:0]  fma_c;
    logic [FP_W-1:0]  fma_d;
    logic             out_valid;
    logic             out_ready;
    logic [FP_W-1:0]  out_data;
    logic [CNT_W-1:0] out_count;

    modport slave (
        input  in_valid, in_a, in_b, in_last, fma_d, out_ready,
        output in_ready, fma_a, fma_b, fma_c, out_valid, out_data, out_count
    );

    modport master (
        output in_valid, in_a, in_b, in_last, fma_d, out_ready,
        input  in_ready, fma_a, fma_b, fma_c, out_valid, out_data, out_count
    );

endinterface

// File: rtl/fma_dot_seq.sv
// Feeds operand pairs one at a time into an external FMA core, folding each
// result back as the next addend, and returns the sum when the last term lands.
module fma_dot_seq
    import fma_pkg::*;
#(
    parameter int unsigned FMA_LAT = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic         clk,
    input  logic         rst,
    fma_dot_seq_if.slave bus
);

    state_e           state_q, state_d;
    logic [FP_W-1:0]  acc_q, acc_d;
    logic [FP_W-1:0]  fma_a_q, fma_a_d;
    logic [FP_W-1:0]  fma_b_q, fma_b_d;
    logic [FP_W-1:0]  fma_c_q, fma_c_d;
    logic             last_q, last_d;
    logic             out_valid_q, out_valid_d;
    logic [FP_W-1:0]  out_data_q, out_data_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic [CNT_W-1:0] term_q, term_d;
    logic [3:0]       wait_q, wait_d;
    logic             take_s;

    assign take_s = bus.in_valid && (state_q == IDLE);

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.fma_a     = fma_a_q;
    assign bus.fma_b     = fma_b_q;
    assign bus.fma_c     = fma_c_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_count = out_count_q;

    // Next-state and datapath updates for the IDLE/WAIT/DONE controller
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        fma_a_d     = fma_a_q;
        fma_b_d     = fma_b_q;
        fma_c_d     = fma_c_q;
        last_d      = last_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        term_d      = term_q;
        wait_d      = wait_q;
        case (state_q)
            IDLE: begin
                if (take_s) begin
                    fma_a_d = bus.in_a;
                    fma_b_d = bus.in_b;
                    fma_c_d = acc_q;
                    last_d  = bus.in_last;
                    term_d  = (term_q == {CNT_W{1'b1}}) ? term_q : term_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    wait_d  = 4'(FMA_LAT);
                    state_d = WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                wait_d = wait_q - 4'd1;
                // wait_q==1 is the edge exactly FMA_LAT edges after operand load
                if (wait_q == 4'd1) begin
                    acc_d = bus.fma_d;
                    if (last_q) begin
                        out_data_d  = bus.fma_d;
                        out_count_d = term_q;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = WAIT;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    acc_d       = FP_POS_ZERO;
                    term_d      = {CNT_W{1'b0}};
                    state_d     = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= FP_POS_ZERO;
            fma_a_q     <= {FP_W{1'b0}};
            fma_b_q     <= {FP_W{1'b0}};
            fma_c_q     <= {FP_W{1'b0}};
            last_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= {FP_W{1'b0}};
            out_count_q <= {CNT_W{1'b0}};
            term_q      <= {CNT_W{1'b0}};
            wait_q      <= 4'd0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            fma_a_q     <= fma_a_d;
            fma_b_q     <= fma_b_d;
            fma_c_q     <= fma_c_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            term_q      <= term_d;
            wait_q      <= wait_d;
        end
    end

endmodule

// File: doc/fma_dot_seq.md
Name: fma_dot_seq

Overview:
Sequential initiator for the single-precision fused multiply-add datapath (D = A*B + C). It accepts a stream of FP32 operand pairs and drives them into an external FMA core, feeding each result back as the next addend. It returns the dot product when the element flagged last completes. It sits between a streaming producer and the FMA core; the parent instantiates both.

Parameters:
FMA_LAT, 1, cycles from the edge that registers fma_a/fma_b/fma_c to the edge that samples fma_d (legal range 1..15).
CNT_W, 16, width of the term counter out_count.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept a pair this cycle
in_a  input  32  FP32 multiplicand
in_b  input  32  FP32 multiplier
in_last  input  1  marks final pair of the vector
fma_a  output  32  registered operand A to FMA core
fma_b  output  32  registered operand B to FMA core
fma_c  output  32  registered addend (running accumulator) to FMA core
fma_d  input  32  FMA core result
out_valid  output  1  dot-product result valid
out_ready  input  1  consumer accepts result
out_data  output  32  FP32 dot product
out_count  output  CNT_W  number of terms in the vector

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: state=IDLE; acc=32'h0000_0000 (+0.0); fma_a/b/c=0; out_valid=0; out_data=0; out_count=0; term count=0; wait counter=0.
- Reset asserted in any state, including mid-WAIT or DONE, aborts the operation. The in-flight FMA result is discarded and no out_valid is produced.
- in_ready = 1 only in IDLE. Handshake fires on in_valid & in_ready.
- States:
  - IDLE:
    - On handshake: fma_a<=in_a, fma_b<=in_b, fma_c<=acc, last_r<=in_last.
    - Term count increments and saturates at all-ones.
    - Wait counter<=FMA_LAT; go to WAIT.
    - No handshake: hold.
  - WAIT:
    - Wait counter decrements each cycle.
    - On the edge where it reaches 0 (exactly FMA_LAT edges after the operand-register edge), acc<=fma_d.
    - If last_r: out_data<=fma_d, out_count<=term count, out_valid<=1, go to DONE.
    - Else go to IDLE.
    - fma_a/b/c are held stable throughout WAIT.
  - DONE:
    - out_valid=1; out_data and out_count held stable.
    - On out_valid & out_ready: out_valid<=0, acc<=+0.0, term count<=0, go to IDLE.
    - in_ready=0 for the whole of DONE, so no overlap of consecutive vectors.
- Throughput: one term per FMA_LAT+1 cycles.
- Latency: the last term accepted at edge N gives out_valid high after edge N+FMA_LAT.
- Arithmetic:
  - No FP interpretation inside the block. fma_d is passed through bit-exact, including NaN, Inf and -0.0.
  - Each vector starts with addend +0.0.
- A single-element vector (in_last on the first pair) is legal and yields in_a*in_b + 0.0.
- in_valid while not in IDLE is ignored. The producer must hold its data until the handshake.

Decomposition:
- Shared package fma_pkg holds:
  - FP32 width constants (EXP_W=8, MAN_W=23, FP_W=32);
  - FP_POS_ZERO=32'h0000_0000;
  - the state enumeration (IDLE, WAIT, DONE).
- No sub-module. The wait counter and FSM stay in this module. The FMA core is instantiated by the parent.

Test Plan:
- FMA_LAT=1, pairs (3F800000,40400000) then (40000000,40800000, last) -> out_data=41300000 (11.0), out_count=2, out_valid exactly 1 cycle after the second operand sample edge; in_ready low 1 cycle between terms.
- Single pair (40000000,40400000, last) -> fma_c=00000000 presented; out_data=40C00000 (6.0), out_count=1.
- Cancellation: (40000000,40400000), (C0000000,40400000, last) -> out_data=00000000, out_count=2; the next vector starts with fma_c=00000000.
- Backpressure: out_ready low 5 cycles after out_valid -> out_data/out_count stable, in_ready=0 throughout; accepted on the first out_ready cycle, in_ready=1 on the next cycle.
- FMA_LAT=3: three pairs of (3F800000,3F800000), last on the third -> out_data=40400000; in_ready high at cycles 0, 4, 8; fma_a/b/c stable during each WAIT.
- rst asserted during WAIT of the first term -> all outputs at reset values next cycle; the following vector (40800000,3F800000, last) yields 40800000 with out_count=1.
